// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a single outstanding memory request,
// a registered output stage and a one-entry skid buffer.
//
// Ports:
//   Clock, Reset         - rising-edge clock, async active-low reset
//   Stall                - downstream not accepting (consume = InstrValid & !Stall)
//   BranchTaken/Target   - redirect; target bits [1:0] forced to 00
//   IMemReq/IMemAddr     - read request and word-aligned address
//   IMemAck/IMemData     - read completion, data valid in the ack cycle
//   Instruction/PCPlus4  - registered instruction and its fetch address + 4
//   InstrValid           - output register holds an unconsumed instruction
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic [31:0] Instruction,
    output logic [31:0] PCPlus4,
    output logic        InstrValid
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] tgt;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc4;
    logic        discard;
    logic [31:0] pend_tgt;

    assign tgt      = BranchTarget & ~32'h3;
    assign pc_next  = pc + 32'd4;   // wraps modulo 2^32
    assign IMemReq  = (state == REQ);
    // pc only changes on ack or outside REQ, so the address is stable
    // for the life of each request, including one being discarded.
    assign IMemAddr = pc;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            Instruction <= '0;
            PCPlus4     <= '0;
            InstrValid  <= 1'b0;
            skid_instr  <= '0;
            skid_pc4    <= '0;
            discard     <= 1'b0;
            pend_tgt    <= '0;
        end else begin
            // Consumption clears valid unless a load below overrides it.
            if (InstrValid && !Stall)
                InstrValid <= 1'b0;

            case (state)
                IDLE: begin
                    state <= REQ;
                    if (BranchTaken) begin
                        InstrValid <= 1'b0;
                        pc         <= tgt;
                    end
                end

                REQ: begin
                    if (BranchTaken) begin
                        InstrValid <= 1'b0;
                        if (IMemAck) begin
                            // Request completes now: drop data, go straight
                            // to the target.
                            pc      <= tgt;
                            discard <= 1'b0;
                        end else begin
                            // Request still in flight: remember the target
                            // (last redirect wins) and drop its data later.
                            discard  <= 1'b1;
                            pend_tgt <= tgt;
                        end
                    end else if (IMemAck) begin
                        if (discard) begin
                            pc      <= pend_tgt;
                            discard <= 1'b0;
                        end else if (!InstrValid || !Stall) begin
                            Instruction <= IMemData;
                            PCPlus4     <= pc_next;
                            InstrValid  <= 1'b1;
                            pc          <= pc_next;
                        end else begin
                            // Output register busy: park the word and stop
                            // requesting until the stall releases.
                            skid_instr <= IMemData;
                            skid_pc4   <= pc_next;
                            pc         <= pc_next;
                            state      <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    // The skid entry is full exactly while in HOLD, so
                    // leaving HOLD is what empties it.
                    if (BranchTaken) begin
                        InstrValid <= 1'b0;
                        pc         <= tgt;
                        state      <= REQ;
                    end else if (!Stall) begin
                        Instruction <= skid_instr;
                        PCPlus4     <= skid_pc4;
                        InstrValid  <= 1'b1;
                        state       <= REQ;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
